// File: rtl/locked_seq_pkg.sv
// Shared types and helpers for the key-locked sequence controller family.
// Consumers that build the relock option define LOCKED_SEQ_RELOCK_EN.
package locked_seq_pkg;

    localparam int ROT_MAX_W = 64;
    localparam logic [7:0] DEFAULT_KEY_VALUE = 8'hA5;

    typedef logic [1:0] state_t;
    localparam state_t ST_KEY  = 2'd0;
    localparam state_t ST_IDLE = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    typedef logic [7:0] stage_idx_t;

    // Rotations over the low w bits of v; bits above w must be zero on entry.
    function automatic logic [ROT_MAX_W-1:0] rot_left(input logic [ROT_MAX_W-1:0] v,
                                                      input int unsigned w);
        logic [ROT_MAX_W-1:0] mask;
        mask = {ROT_MAX_W{1'b1}} >> (ROT_MAX_W - w);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

    function automatic logic [ROT_MAX_W-1:0] rot_right(input logic [ROT_MAX_W-1:0] v,
                                                       input int unsigned w);
        logic [ROT_MAX_W-1:0] mask;
        mask = {ROT_MAX_W{1'b1}} >> (ROT_MAX_W - w);
        return ((v >> 1) | (v << (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/locked_seq_ctrl_if.sv
// Handshake/data bundle between the locked sequence controller and its driver.
// The relock input exists only when LOCKED_SEQ_RELOCK_EN is defined.
interface locked_seq_ctrl_if #(
    parameter int KEY_W = 4,
    parameter int LEN_W = 5,
    parameter int OUT_W = 23
);
    logic [KEY_W-1:0] keyinput;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [OUT_W-1:0] y;
    logic             busy;
    logic             done;
    logic             key_phase;
`ifdef LOCKED_SEQ_RELOCK_EN
    logic             relock;

    modport master (output keyinput, start, len, relock,
                    input  y, busy, done, key_phase);
    modport slave  (input  keyinput, start, len, relock,
                    output y, busy, done, key_phase);
`else
    modport master (output keyinput, start, len,
                    input  y, busy, done, key_phase);
    modport slave  (input  keyinput, start, len,
                    output y, busy, done, key_phase);
`endif
endinterface

// File: rtl/locked_seq_ctrl_key_stage_chk.sv
// Multi-stage key preamble: one key chunk per cycle, accumulated into key_ok.
// Stage timing never depends on whether the chunks match.
module key_stage_chk
    import locked_seq_pkg::*;
#(
    parameter int                          KEY_W      = 4,
    parameter int                          NUM_STAGES = 2,
    parameter logic [NUM_STAGES*KEY_W-1:0] KEY_VALUE  = DEFAULT_KEY_VALUE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [KEY_W-1:0] keyinput,
    output logic             key_ok,
    output logic             key_phase,
    output logic             preamble_done
);

    stage_idx_t stage;
    logic       in_key;
    logic       chunk_ok;
    logic       last_stage;

    always_comb begin
        chunk_ok = 1'b0;
        for (int g = 0; g < NUM_STAGES; g++) begin
            if (stage == stage_idx_t'(g)) begin
                chunk_ok = (keyinput == KEY_VALUE[g*KEY_W +: KEY_W]);
            end
        end
    end

    assign last_stage    = (stage == stage_idx_t'(NUM_STAGES - 1));
    assign key_phase     = in_key;
    assign preamble_done = in_key && last_stage;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage  <= '0;
            in_key <= 1'b1;
            key_ok <= 1'b1;
        end else if (restart) begin
            stage  <= '0;
            in_key <= 1'b1;
            key_ok <= 1'b1;
        end else if (in_key) begin
            key_ok <= key_ok & chunk_ok;
            if (last_stage) begin
                stage  <= '0;
                in_key <= 1'b0;
            end else begin
                stage <= stage + 1'b1;
            end
        end
    end

endmodule

// File: rtl/locked_seq_ctrl.sv
// Key-locked run sequencer: a wrong key is silent until CNT_LIMIT runs have
// completed, after which runs rotate y the wrong way. Option: LOCKED_SEQ_RELOCK_EN.
module locked_seq_ctrl
    import locked_seq_pkg::*;
#(
    parameter int                          KEY_W      = 4,
    parameter int                          NUM_STAGES = 2,
    parameter logic [NUM_STAGES*KEY_W-1:0] KEY_VALUE  = DEFAULT_KEY_VALUE,
    parameter int                          OUT_W      = 23,
    parameter int                          LEN_W      = 5,
    parameter int                          CNT_LIMIT  = 5
) (
    input  logic               clk,
    input  logic               rst,
    locked_seq_ctrl_if.slave   bus
);

    localparam int RUNS_W = $clog2(CNT_LIMIT + 1);

    function automatic logic [RUNS_W-1:0] sat_inc(input logic [RUNS_W-1:0] v);
        return (v >= RUNS_W'(CNT_LIMIT)) ? v : v + 1'b1;
    endfunction

    state_t            state;
    logic [LEN_W-1:0]  cnt;
    logic [RUNS_W-1:0] runs;
    logic [OUT_W-1:0]  y_q;
    logic              dev;
    logic              key_ok;
    logic              key_phase;
    logic              preamble_done;
    logic              relock_req;
    logic              illegal;
    logic              restart;

`ifdef LOCKED_SEQ_RELOCK_EN
    assign relock_req = (state == ST_IDLE) && bus.relock;
`else
    assign relock_req = 1'b0;
`endif

    always_comb begin
        illegal = 1'b0;
        case (state)
            ST_KEY, ST_IDLE, ST_RUN, ST_DONE: illegal = 1'b0;
            default:                          illegal = 1'b1;
        endcase
    end

    assign restart = relock_req | illegal;

    key_stage_chk #(
        .KEY_W      (KEY_W),
        .NUM_STAGES (NUM_STAGES),
        .KEY_VALUE  (KEY_VALUE)
    ) u_key_chk (
        .clk           (clk),
        .rst           (rst),
        .restart       (restart),
        .keyinput      (bus.keyinput),
        .key_ok        (key_ok),
        .key_phase     (key_phase),
        .preamble_done (preamble_done)
    );

    assign bus.y         = y_q;
    assign bus.busy      = (state == ST_RUN);
    assign bus.done      = (state == ST_DONE);
    assign bus.key_phase = key_phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_KEY;
            cnt   <= '0;
            runs  <= '0;
            y_q   <= '0;
            dev   <= 1'b0;
        end else begin
            case (state)
                ST_KEY: begin
                    if (preamble_done) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (relock_req) begin
                        state <= ST_KEY;
                        runs  <= '0;
                    end else if (bus.start) begin
                        cnt <= bus.len;
                        // Direction is fixed for the whole run at acceptance.
                        dev <= !key_ok && (runs >= RUNS_W'(CNT_LIMIT));
                        if (bus.len != '0) begin
                            state <= ST_RUN;
                            y_q   <= OUT_W'(1);
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt > LEN_W'(1)) begin
                        cnt <= cnt - 1'b1;
                        y_q <= dev ? OUT_W'(rot_right(ROT_MAX_W'(y_q), OUT_W))
                                   : OUT_W'(rot_left(ROT_MAX_W'(y_q), OUT_W));
                    end else begin
                        y_q   <= '0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (!key_ok) runs <= sat_inc(runs);
                end
                default: begin
                    state <= ST_KEY;
                    y_q   <= '0;
                end
            endcase
        end
    end

endmodule
